// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: opcode constants,
// FSM state encoding, jump condition codes and instruction field positions.
package pc_sequencer_pkg;

  // Instruction layout: [17:14] opcode, [13:11] cond, [10:0] offset
  localparam int unsigned OPC_MSB  = 17;
  localparam int unsigned OPC_LSB  = 14;
  localparam int unsigned COND_MSB = 13;
  localparam int unsigned COND_LSB = 11;
  localparam int unsigned OFF_MSB  = 10;
  localparam int unsigned OFF_LSB  = 0;

  localparam logic [3:0] OP_CMP  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CC_JMP = 3'd0,
    CC_JE  = 3'd1,
    CC_JA  = 3'd2,
    CC_JB  = 3'd3,
    CC_JAE = 3'd4,
    CC_JBE = 3'd5
  } cond_t;

  // Codes 6 and 7 are reserved; such jumps execute as a NOP.
  function automatic logic cond_is_reserved(input logic [2:0] c);
    return (c > 3'(CC_JBE));
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_incrementer.sv
// pc_incrementer: ADDR_W-bit program counter +1, wrapping modulo 2^ADDR_W.
//  i_pc      current program counter
//  o_pc_inc  i_pc + 1 (carry out discarded)
module pc_incrementer #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic [ADDR_W-1:0] i_pc,
  output logic [ADDR_W-1:0] o_pc_inc
);

  assign o_pc_inc = i_pc + ADDR_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and ZF/CF flags, steps the core
// through IDLE -> FETCH -> DECODE -> EXEC, drives the jump resolver and
// loads its returned target.
//  clk, rst_n            core clock, async active-low reset
//  imem_req/addr/ack/data instruction fetch handshake
//  exec_start/exec_done   ALU handshake, alu_zf/alu_cf flag results
//  ir, pc                 instruction register, program counter
//  jump_signal/cond/offset, zf, cf  jump resolver inputs
//  jump_target            resolver result, loaded while jump_signal is high
//  halted                 high while in HALT
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 11,
  parameter int unsigned       INSTR_W  = 18,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               exec_start,
  input  logic               exec_done,
  input  logic               alu_zf,
  input  logic               alu_cf,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  pc,
  output logic               jump_signal,
  output logic [2:0]         jump_cond,
  output logic [ADDR_W-1:0]  jump_offset,
  output logic               zf,
  output logic               cf,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               halted
);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt, w_pc_inc;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
  logic                r_zf, w_zf_nxt, r_cf, w_cf_nxt;
  logic                r_imem_req, w_req_nxt;
  logic [ADDR_W-1:0]   r_imem_addr, w_addr_nxt;
  logic                r_exec_start, w_start_nxt;
  logic                r_jump_signal, w_jsig_nxt;
  logic                r_halted, w_halted_nxt;

  logic [3:0]          w_opcode;
  logic [2:0]          w_cond;
  logic                w_is_jmp, w_is_cmp, w_is_halt;

  assign w_opcode  = r_ir[OPC_MSB:OPC_LSB];
  assign w_cond    = r_ir[COND_MSB:COND_LSB];
  assign w_is_jmp  = (w_opcode == OP_JMP);
  assign w_is_cmp  = (w_opcode == OP_CMP);
  assign w_is_halt = (w_opcode == OP_HALT);

  pc_incrementer #(.ADDR_W(ADDR_W)) u_pc_inc (
    .i_pc     (r_pc),
    .o_pc_inc (w_pc_inc)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_zf_nxt     = r_zf;
    w_cf_nxt     = r_cf;
    w_req_nxt    = 1'b0;
    w_addr_nxt   = r_imem_addr;
    w_start_nxt  = 1'b0;
    w_jsig_nxt   = 1'b0;
    w_halted_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = r_pc;
      end
      ST_FETCH: begin
        if (r_imem_req && imem_ack) begin
          w_ir_nxt    = imem_data;
          w_state_nxt = ST_DECODE;
        end else begin
          w_req_nxt   = 1'b1;
        end
      end
      ST_DECODE: begin
        // Strobes are registered here so they are high during the first EXEC cycle.
        w_state_nxt = ST_EXEC;
        if (w_is_jmp) begin
          w_jsig_nxt  = !cond_is_reserved(w_cond);
        end else if (!w_is_halt) begin
          w_start_nxt = 1'b1;
        end
      end
      ST_EXEC: begin
        if (w_is_halt) begin
          w_state_nxt  = ST_HALT;
          w_halted_nxt = 1'b1;
        end else if (w_is_jmp) begin
          w_pc_nxt    = r_jump_signal ? jump_target : w_pc_inc;
          w_state_nxt = ST_FETCH;
        end else if (exec_done) begin
          w_pc_nxt    = w_pc_inc;
          if (w_is_cmp) begin
            w_zf_nxt = alu_zf;
            w_cf_nxt = alu_cf;
          end
          w_state_nxt = ST_FETCH;
        end
        if (w_state_nxt == ST_FETCH) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = w_pc_nxt;
        end
      end
      ST_HALT: begin
        w_halted_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_ir          <= '0;
      r_zf          <= 1'b0;
      r_cf          <= 1'b0;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= '0;
      r_exec_start  <= 1'b0;
      r_jump_signal <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ir          <= w_ir_nxt;
      r_zf          <= w_zf_nxt;
      r_cf          <= w_cf_nxt;
      r_imem_req    <= w_req_nxt;
      r_imem_addr   <= w_addr_nxt;
      r_exec_start  <= w_start_nxt;
      r_jump_signal <= w_jsig_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign exec_start  = r_exec_start;
  assign ir          = r_ir;
  assign pc          = r_pc;
  assign jump_signal = r_jump_signal;
  assign jump_cond   = w_cond;
  assign jump_offset = ADDR_W'(r_ir[OFF_MSB:OFF_LSB]);
  assign zf          = r_zf;
  assign cf          = r_cf;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned IW = 18;
  localparam logic [AW-1:0] RPC = 11'h000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req, imem_ack;
  logic [AW-1:0] imem_addr, pc, jump_offset, jump_target;
  logic [IW-1:0] imem_data, ir;
  logic          exec_start, exec_done, alu_zf, alu_cf;
  logic          jump_signal, zf, cf, halted;
  logic [2:0]    jump_cond;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .exec_start(exec_start), .exec_done(exec_done), .alu_zf(alu_zf), .alu_cf(alu_cf),
    .ir(ir), .pc(pc), .jump_signal(jump_signal), .jump_cond(jump_cond),
    .jump_offset(jump_offset), .zf(zf), .cf(cf), .jump_target(jump_target), .halted(halted)
  );

  // Jump resolver: taken -> pc+offset, else pc+1
  function automatic logic taken(input logic [2:0] c, input logic z, input logic cy);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z && !cy;
      3'd3:    return cy;
      3'd4:    return !cy;
      3'd5:    return z || cy;
      default: return 1'b0;
    endcase
  endfunction

  assign jump_target = taken(jump_cond, zf, cf) ? pc + jump_offset : pc + 11'd1;

  typedef struct { logic zf; logic cf; int unsigned dly; } alu_t;
  typedef struct { bit is_goto; logic [17:0] instr; logic [10:0] tgt;
                   bit fix; logic zf; logic cf; int unsigned dly; } forced_t;

  int unsigned   n_vec = 0, n_err = 0, n_issued = 0, spur_cnt = 0;
  bit            hold_ack = 0;
  logic [10:0]   addr_q[$];
  logic [26:0]   jmp_q[$];
  alu_t          alu_q[$];
  forced_t       forced_q[$];
  logic [10:0]   m_pc;
  logic          m_zf, m_cf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    n_vec++; n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Architectural reference: effect of one instruction on pc/flags
  task automatic model_step(input logic [17:0] ins, input alu_t a);
    logic [3:0] op; logic [2:0] c; logic [10:0] off;
    op = ins[17:14]; c = ins[13:11]; off = ins[10:0];
    if (op == OP_HALT) begin
      // no further fetch expected
    end else if (op == OP_JMP) begin
      if (c <= 3'd5) begin
        jmp_q.push_back({c, off, m_pc, m_zf, m_cf});
        m_pc = taken(c, m_zf, m_cf) ? m_pc + off : m_pc + 11'd1;
      end else begin
        m_pc = m_pc + 11'd1;
      end
      addr_q.push_back(m_pc);
    end else begin
      alu_q.push_back(a);
      if (op == OP_CMP) begin m_zf = a.zf; m_cf = a.cf; end
      m_pc = m_pc + 11'd1;
      addr_q.push_back(m_pc);
    end
  endtask

  function automatic logic [17:0] rand_instr();
    int unsigned r = $urandom_range(0, 9);
    logic [3:0]  op;
    logic [2:0]  c = 3'($urandom);
    logic [10:0] off = 11'($urandom);
    if (r < 4)      op = 4'($urandom_range(0, 12));
    else if (r < 6) op = OP_CMP;
    else            op = OP_JMP;
    return {op, c, off};
  endfunction

  // Instruction memory responder
  initial begin : imem_drv
    bit pend; int unsigned w; forced_t f; logic [17:0] ins; alu_t a;
    pend = 0; w = 0; imem_ack = 0; imem_data = '0;
    forever begin
      @(negedge clk);
      imem_ack = 0; imem_data = 18'($urandom);
      if (!rst_n) pend = 0;
      if (!imem_req) begin
        if (spur_cnt > 0 || $urandom_range(0, 7) == 0) begin
          imem_ack = 1;
          if (spur_cnt > 0) spur_cnt--;
        end
      end else if (rst_n && !hold_ack) begin
        if (!pend) begin pend = 1; w = $urandom_range(0, 3); end
        if (w == 0) begin
          pend = 0;
          a.zf = 1'($urandom); a.cf = 1'($urandom); a.dly = $urandom_range(0, 3);
          if (forced_q.size() > 0) begin
            f = forced_q.pop_front();
            ins = f.is_goto ? {OP_JMP, 3'd0, 11'(f.tgt - m_pc)} : f.instr;
            if (f.fix) begin a.zf = f.zf; a.cf = f.cf; a.dly = f.dly; end
          end else begin
            ins = rand_instr();
          end
          imem_ack = 1; imem_data = ins;
          model_step(ins, a);
          n_issued++;
        end else begin
          w--;
        end
      end
    end
  end

  // ALU responder
  initial begin : alu_drv
    bit busy; int unsigned w; alu_t cur;
    busy = 0; w = 0; cur = '{1'b0, 1'b0, 0};
    exec_done = 0; alu_zf = 0; alu_cf = 0;
    forever begin
      @(negedge clk);
      exec_done = 0; alu_zf = 1'($urandom); alu_cf = 1'($urandom);
      if (!rst_n) begin
        busy = 0;
      end else begin
        if (exec_start) begin
          if (busy || alu_q.size() == 0) miss("exec_start_unexpected");
          else begin
            n_vec++;
            cur = alu_q.pop_front(); busy = 1; w = cur.dly;
          end
        end
        if (busy) begin
          if (w == 0) begin
            exec_done = 1; alu_zf = cur.zf; alu_cf = cur.cf; busy = 0;
          end else w--;
        end else if (!exec_start && $urandom_range(0, 7) == 0) begin
          exec_done = 1;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin : mon
    logic prev_req, prev_js;
    prev_req = 0; prev_js = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_req && !prev_req) begin
          if (addr_q.size() == 0) miss("fetch_unexpected");
          else chk("fetch_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
        end
        if (jump_signal) begin
          if (prev_js)                miss("jump_signal_width");
          else if (jmp_q.size() == 0) miss("jump_signal_unexpected");
          else chk("jump_inputs", 32'({jump_cond, jump_offset, pc, zf, cf}), 32'(jmp_q.pop_front()));
        end
      end
      prev_req = imem_req; prev_js = jump_signal;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_goto(input logic [10:0] t);
    forced_q.push_back('{1'b1, 18'h0, t, 1'b0, 1'b0, 1'b0, 0});
  endtask

  task automatic push_ins(input logic [17:0] ins, input bit fix, input logic z,
                          input logic cy, input int unsigned d);
    forced_q.push_back('{1'b0, ins, 11'h0, fix, z, cy, d});
  endtask

  // Wait until all forced instructions are issued and the last one has completed
  task automatic drain_forced(input string tag);
    int unsigned k; logic pr;
    k = 0;
    while (forced_q.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    pr = imem_req;
    while (k < 3000) begin
      @(negedge clk); k++;
      if (imem_req && !pr) break;
      pr = imem_req;
    end
    if (k >= 3000) miss({tag, "_timeout"});
  endtask

  initial begin : main
    int unsigned k, tgt;
    m_pc = RPC; m_zf = 0; m_cf = 0;
    addr_q.push_back(RPC);
    // 1: ALU op at 0, done 2 cycles after exec_start
    push_ins({4'h1, 3'd0, 11'h055}, 1'b1, 1'b1, 1'b1, 2);
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_exec_start", 32'(exec_start), 0);
    chk("rst_jump_signal", 32'(jump_signal), 0);
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_ir", 32'(ir), 0);
    chk("rst_flags", 32'({zf, cf, halted}), 0);
    rst_n = 1;
    drain_forced("t1");
    chk("t1_pc", 32'(pc), 1);
    chk("t1_flags", 32'({zf, cf}), 0);

    // 2: CMP zf=1 cf=0 at 0, JE +5 at pc=1 -> pc=6
    push_goto(11'h000);
    push_ins({OP_CMP, 3'd0, 11'h000}, 1'b1, 1'b1, 1'b0, 0);
    push_ins({OP_JMP, 3'd1, 11'd5}, 1'b0, 1'b0, 1'b0, 0);
    drain_forced("t2");
    chk("t2_pc", 32'(pc), 6);
    chk("t2_flags", 32'({zf, cf}), 32'(2'b10));

    // 3: ALU op at 7FF wraps to 0; flags hold
    push_goto(11'h7FF);
    push_ins({4'h3, 3'd0, 11'h000}, 1'b1, 1'b0, 1'b1, 0);
    drain_forced("t3");
    chk("t3_pc_wrap", 32'(pc), 0);
    chk("t3_flags_hold", 32'({zf, cf}), 32'(2'b10));

    // 4: reserved cond 6 at pc=10 -> NOP
    push_goto(11'd10);
    push_ins({OP_JMP, 3'd6, 11'h123}, 1'b0, 1'b0, 1'b0, 0);
    drain_forced("t4");
    chk("t4_pc", 32'(pc), 11);

    // Random program
    tgt = n_issued + 250; k = 0;
    while (n_issued < tgt && k < 8000) begin @(negedge clk); k++; end
    if (k >= 8000) miss("random_timeout");

    // 5: reset while imem_req is high, stray ack right after release
    hold_ack = 1; k = 0;
    do begin @(negedge clk); k++; end while (!imem_req && k < 100);
    if (k >= 100) miss("t5_wait_req_timeout");
    rst_n = 0;
    #1;
    chk("t5_req_drop", 32'(imem_req), 0);
    chk("t5_strobes_drop", 32'({exec_start, jump_signal}), 0);
    chk("t5_pc_reset", 32'(pc), 32'(RPC));
    addr_q.delete(); jmp_q.delete(); alu_q.delete();
    m_pc = RPC; m_zf = 0; m_cf = 0;
    addr_q.push_back(RPC);
    @(negedge clk);
    @(posedge clk);
    spur_cnt = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t5_ir_ignored", 32'(ir), 0);
    chk("t5_refetch", 32'({imem_req, imem_addr}), 32'({1'b1, RPC}));
    hold_ack = 0;

    // 6: HALT at pc=3
    push_goto(11'd3);
    push_ins({OP_HALT, 3'd0, 11'h000}, 1'b0, 1'b0, 1'b0, 0);
    k = 0;
    while (!halted && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) miss("t6_halt_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_halt_state", 32'({imem_req, halted, pc}), 32'({1'b0, 1'b1, 11'd3}));
    end
    chk("t6_queues_empty", 32'(addr_q.size() + jmp_q.size() + alu_q.size()), 0);
    rst_n = 0;
    #1;
    chk("t6_reset_clears_halt", 32'({halted, pc}), 32'({1'b0, RPC}));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
